// File: rtl/fetch_pc_seq_if.sv
// Fetch unit bus bundle: instruction-memory req/gnt/rvalid channel plus the
// valid/ready channel that hands fetched words to decode.
interface fetch_pc_seq_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 32
);
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_gnt;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] instr;
   logic [PC_W-1:0]    instr_pc;
   logic               instr_valid;
   logic               dec_ready;

   modport master (
      output imem_req, imem_addr, instr, instr_pc, instr_valid,
      input  imem_gnt, imem_rvalid, imem_rdata, dec_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_pc, instr_valid,
      output imem_gnt, imem_rvalid, imem_rdata, dec_ready
   );
endinterface

// File: rtl/fetch_pc_seq.sv
// Program-counter sequencer and fetch controller: one outstanding imem request,
// branch redirects from senable/etq, halts once the EXIT_PC instruction is taken.
module fetch_pc_seq #(
   parameter int              PC_W     = 8,
   parameter int              PC_STEP  = 4,
   parameter logic [PC_W-1:0] RESET_PC = 8'h00,
   parameter logic [PC_W-1:0] EXIT_PC  = 8'h80,
   parameter int              INSTR_W  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic            senable,
   input  logic [PC_W-1:0] etq,
   output logic            halt,
   fetch_pc_seq_if.master  bus
);

   localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

   typedef enum logic [2:0] {IDLE, REQ, WAIT_RSP, HOLD, HALT} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [PC_W-1:0]    pc;
   logic [PC_W-1:0]    fetch_pc;
   logic               kill;
   logic [INSTR_W-1:0] instr_q;
   logic [PC_W-1:0]    instr_pc_q;
   logic               instr_valid_q;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // A redirect always forces a fresh request; a response that is killed or
   // collides with a redirect is dropped and the fetch restarts from pc.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (run) state_nxt = REQ;
         REQ:      if (bus.imem_gnt) state_nxt = WAIT_RSP;
         WAIT_RSP: if (bus.imem_rvalid) state_nxt = (kill || senable) ? REQ : HOLD;
         HOLD: begin
            if (senable)                    state_nxt = REQ;
            else if (bus.dec_ready) begin
               if (instr_pc_q == EXIT_PC)   state_nxt = HALT;
               else if (run)                state_nxt = REQ;
               else                         state_nxt = IDLE;
            end
         end
         HALT:     state_nxt = HALT;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.imem_req    = (state == REQ);
      bus.imem_addr   = pc;
      bus.instr       = instr_q;
      bus.instr_pc    = instr_pc_q;
      bus.instr_valid = instr_valid_q;
   end

   // kill marks the single in-flight request as stale after a redirect, so its
   // response is discarded whenever it eventually returns.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= RESET_PC;
         fetch_pc      <= '0;
         kill          <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         halt          <= 1'b0;
      end else begin
         case (state)
            REQ: begin
               if (bus.imem_gnt) begin
                  fetch_pc <= pc;
                  if (senable) kill <= 1'b1;
               end
            end
            WAIT_RSP: begin
               if (bus.imem_rvalid) begin
                  kill <= 1'b0;
                  if (!kill && !senable) begin
                     instr_q       <= bus.imem_rdata;
                     instr_pc_q    <= fetch_pc;
                     instr_valid_q <= 1'b1;
                     pc            <= fetch_pc + STEP;
                  end
               end else if (senable) begin
                  kill <= 1'b1;
               end
            end
            HOLD: begin
               if (senable || bus.dec_ready) begin
                  instr_valid_q <= 1'b0;
                  if (!senable && instr_pc_q == EXIT_PC) halt <= 1'b1;
               end
            end
            default: ;
         endcase
         if (senable && state != HALT) pc <= etq;
      end
   end

endmodule
